fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
- Output-side reader of the radix-2 FFT pipeline. Accepts complex FP32 results in bit-reversed order from the last butterfly stage and re-emits them in natural order.
- Ping-pong double buffer, one frame per bank. Sustains one sample per clock when both handshakes stay high.
- Sits between the final butterfly stage and the downstream consumer. Valid/ready handshake on both sides.

Parameters:
- N_LOG2, 3, log2 of FFT length; frame length N = 2**N_LOG2 (legal 1..10).
- DATA_W, 32, width of each real/imag word (IEEE-754 single); data is passed through untouched.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous active-low reset
- i_valid  in  1  upstream sample valid
- o_ready  out  1  block can accept a sample this cycle
- i_real  in  DATA_W  input real part, bit-reversed order
- i_imag  in  DATA_W  input imag part
- o_valid  out  1  output sample valid
- i_ready  in  1  downstream accepts output
- o_real  out  DATA_W  output real part, natural order
- o_imag  out  DATA_W  output imag part
- o_index  out  N_LOG2  natural-order index of the current output
- o_last  out  1  high with o_index == N-1

Behaviour:
- Interface: one clock i_clk; reset i_reset is asynchronous, active-low. All state is cleared on reset assertion, independent of the clock.
- Reset values:
  - o_valid = 0, o_real = 0, o_imag = 0, o_index = 0, o_last = 0.
  - Write bank = 0, read bank = 0, both bank_full flags = 0, wr_cnt = 0, rd_cnt = 0.
- Storage: mem[2][N] of {real, imag}, plus a bank_full[1:0] flag per bank.
- Write side:
  - o_ready = !bank_full[wr_bank], driven combinationally from registers only (never from i_valid).
  - Input handshake is i_valid && o_ready. On it, write mem[wr_bank][bitrev(wr_cnt)], then increment wr_cnt.
  - When wr_cnt == N-1 on a handshake: set bank_full[wr_bank], toggle wr_bank, and wrap wr_cnt to 0.
- Read side:
  - load = bank_full[rd_bank] && (!o_valid || i_ready).
  - On load: o_real/o_imag <= mem[rd_bank][rd_cnt], o_index <= rd_cnt, o_last <= (rd_cnt == N-1), o_valid <= 1, and rd_cnt increments.
  - On a load with rd_cnt == N-1: clear bank_full[rd_bank], toggle rd_bank, and wrap rd_cnt to 0. The bank is freed as soon as its last word is captured in the output register.
  - If i_ready && o_valid && !load, then o_valid <= 0.
  - While o_valid && !i_ready, all outputs hold stable.
- Latency: the final input handshake of a frame occurs in cycle t. o_valid for index 0 of that frame is first high in cycle t+2.
- Throughput: back-to-back frames with both sides ready give continuous o_ready = 1 and, after the initial latency, continuous o_valid = 1.
- Boundaries:
  - Both banks full: o_ready = 0 and upstream stalls. o_ready returns high the cycle after the read side frees a bank.
  - Set of bank_full on one bank and clear on the other in the same cycle: both take effect. The same bank cannot be set and cleared in one cycle by construction.
  - Partial frame at reset: the frame is discarded and no output is produced for it.
  - i_valid while o_ready = 0: ignored, nothing written.
  - Frames are emitted strictly in arrival order.
  - N_LOG2 = 1: bitrev is the identity and the frame length is 2.

Decomposition:
- Shared package fft_pkg holds:
  - FFT_N_LOG2 default constant.
  - complex_t struct {logic [31:0] re, im}.
  - Function bitrev(idx, width), also reused by the FFT stage address generators.
- One natural sub-module: fft_pingpong_ram, a 2-bank N-deep complex register array with one write port and one combinational read port. Bank flags and counters stay in fft_bitrev_reorder.

Test Plan:
- N_LOG2 = 3, i_ready = 1. Feed arrival k = 0..7 with i_real = k, i_imag = 100+k.
  - Required: outputs in order o_real = 0,4,2,6,1,5,3,7 and o_imag = 100 + same.
  - o_index = 0..7, o_last only on index 7, first o_valid 2 cycles after the 8th input handshake.
- Three back-to-back frames, i_valid and i_ready held at 1.
  - Required: o_ready never drops, and after the initial latency o_valid stays high for 24 consecutive cycles.
  - Frame tags (i_imag = 1000·frame + k) emerge in order.
- i_ready = 0 throughout, feed 3 frames.
  - Required: o_ready drops after 16 accepted samples and sample 17 is not written.
  - o_valid is high holding index 0 of frame 0.
  - Raising i_ready drains frame 0, then frame 1, then frame 2.
- Random i_ready (50%) with continuous input.
  - Required: outputs stable whenever o_valid && !i_ready.
  - No sample lost or duplicated, checked by scoreboard against the bitrev model.
- Assert reset after 5 input samples and while output is mid-frame at index 3.
  - Required: all outputs 0 immediately, o_ready = 1 after reset release.
  - The next full frame reorders correctly with no stale data.
- N_LOG2 = 1, input i_real = 10,11.
  - Required: output 10,11 with o_last on the second sample.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_pkg
// Brief    : Shared FFT constants, complex sample type and bit-reverse helper.
// Revision : 1.0
// ============================================================================
package fft_pkg;

    localparam int FFT_N_LOG2   = 3;
    localparam int BITREV_MAX_W = 10;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } complex_t;

    // Reverse the low `width` bits of idx; reverse the full word, then shift down.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] idx,
        input int                      width
    );
        logic [BITREV_MAX_W-1:0] r_full;
        r_full = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            r_full[BITREV_MAX_W-1-i] = idx[i];
        end
        return r_full >> (BITREV_MAX_W - width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_pingpong_ram.sv
`default_nettype none
// ============================================================================
// Module   : fft_pingpong_ram
// Brief    : Two-bank, N-deep complex register array; one write, one comb read.
// Revision : 1.0
// ============================================================================
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_wr_en,
    input  logic                i_wr_bank,
    input  logic [N_LOG2-1:0]   i_wr_addr,
    input  logic [2*DATA_W-1:0] i_wr_data,
    input  logic                i_rd_bank,
    input  logic [N_LOG2-1:0]   i_rd_addr,
    output logic [2*DATA_W-1:0] o_rd_data
);

    localparam int C_DEPTH = 2 << N_LOG2;

    logic [2*DATA_W-1:0] r_mem [C_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[{i_rd_bank, i_rd_addr}];

endmodule
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Brief    : Ping-pong reorder buffer: bit-reversed FFT output -> natural order.
// Revision : 1.0
// ============================================================================
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_real,
    input  logic [DATA_W-1:0] i_imag,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_real,
    output logic [DATA_W-1:0] o_imag,
    output logic [N_LOG2-1:0] o_index,
    output logic              o_last
);

    localparam logic [N_LOG2-1:0] C_LAST = N_LOG2'((1 << N_LOG2) - 1);

    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [1:0]          r_bank_full;
    logic [N_LOG2-1:0]   r_wr_cnt;
    logic [N_LOG2-1:0]   r_rd_cnt;
    logic                r_valid;
    logic [DATA_W-1:0]   r_real;
    logic [DATA_W-1:0]   r_imag;
    logic [N_LOG2-1:0]   r_index;
    logic                r_last;

    logic                w_wr_fire;
    logic                w_wr_wrap;
    logic                w_load;
    logic                w_rd_wrap;
    logic [1:0]          w_bank_full_nxt;
    logic [N_LOG2-1:0]   w_wr_addr;
    logic [2*DATA_W-1:0] w_rd_data;

    assign o_ready   = !r_bank_full[r_wr_bank];
    assign w_wr_fire = i_valid && o_ready;
    assign w_wr_wrap = w_wr_fire && (r_wr_cnt == C_LAST);
    assign w_load    = r_bank_full[r_rd_bank] && (!r_valid || i_ready);
    assign w_rd_wrap = w_load && (r_rd_cnt == C_LAST);
    assign w_wr_addr = N_LOG2'(bitrev(BITREV_MAX_W'(r_wr_cnt), N_LOG2));

    // Set and clear always target different banks, so both may land together.
    always_comb begin
        w_bank_full_nxt = r_bank_full;
        if (w_wr_wrap) w_bank_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_wrap) w_bank_full_nxt[r_rd_bank] = 1'b0;
    end

    fft_pingpong_ram #(
        .N_LOG2 (N_LOG2),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_fire),
        .i_wr_bank (r_wr_bank),
        .i_wr_addr (w_wr_addr),
        .i_wr_data ({i_real, i_imag}),
        .i_rd_bank (r_rd_bank),
        .i_rd_addr (r_rd_cnt),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_bank_full <= 2'b00;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_valid     <= 1'b0;
            r_real      <= '0;
            r_imag      <= '0;
            r_index     <= '0;
            r_last      <= 1'b0;
        end else begin
            r_bank_full <= w_bank_full_nxt;
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_wrap) r_wr_bank <= ~r_wr_bank;
            end
            if (w_load) begin
                r_real   <= w_rd_data[2*DATA_W-1:DATA_W];
                r_imag   <= w_rd_data[DATA_W-1:0];
                r_index  <= r_rd_cnt;
                r_last   <= (r_rd_cnt == C_LAST);
                r_valid  <= 1'b1;
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_rd_wrap) r_rd_bank <= ~r_rd_bank;
            end else if (i_ready && r_valid) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_real  = r_real;
    assign o_imag  = r_imag;
    assign o_index = r_index;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_reorder
// Brief    : Self-checking bench for fft_bitrev_reorder (N=8 and N=2 instances).
// Revision : 1.0
// ============================================================================
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int NL = 3;
    localparam int N  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0] in_real, in_imag, out_real, out_imag;
    logic [2:0]  out_index;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_real, b_in_imag, b_out_real, b_out_imag;
    logic [0:0]  b_out_index;

    fft_bitrev_reorder #(.N_LOG2(NL), .DATA_W(32)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_valid(in_valid), .o_ready(in_ready), .i_real(in_real), .i_imag(in_imag),
        .o_valid(out_valid), .i_ready(out_ready), .o_real(out_real), .o_imag(out_imag),
        .o_index(out_index), .o_last(out_last)
    );

    fft_bitrev_reorder #(.N_LOG2(1), .DATA_W(32)) dut_n2 (
        .i_clk(clk), .i_reset(rst_n),
        .i_valid(b_in_valid), .o_ready(b_in_ready), .i_real(b_in_real), .i_imag(b_in_imag),
        .o_valid(b_out_valid), .i_ready(b_out_ready), .o_real(b_out_real), .o_imag(b_out_imag),
        .o_index(b_out_index), .o_last(b_out_last)
    );

    int        checks = 0;
    int        errors = 0;
    complex_t  part[$];
    complex_t  exp_q[$];
    int        exp_idx_q[$];
    logic [31:0] log_real[$];
    int        cyc = 0, run = 0, max_run = 0, first_out_cyc = -1, last_in_cyc = 0;
    bit        in_fired, hold, chk_ready, s_valid;
    int        s_index;
    logic [63:0] hold_data;
    logic [4:0]  hold_ctl;
    int        data_mode, rdy_mode;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reverse `bits` low bits with plain arithmetic.
    function automatic int rev(input int v, input int bits);
        int r = 0;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic cycle();
        complex_t e;
        int       ei;
        @(negedge clk);
        cyc++;
        if (hold) begin
            check("hold_data", {out_real, out_imag}, hold_data);
            check("hold_ctl", {out_valid, out_last, out_index}, hold_ctl);
        end
        hold      = out_valid && !out_ready;
        hold_data = {out_real, out_imag};
        hold_ctl  = {out_valid, out_last, out_index};
        s_valid   = out_valid;
        s_index   = int'(out_index);
        if (chk_ready) check("ready_steady", in_ready, 1);
        run     = out_valid ? run + 1 : 0;
        max_run = (run > max_run) ? run : max_run;
        if (out_valid && first_out_cyc < 0) first_out_cyc = cyc;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_when_empty", out_valid, 0);
            end else begin
                e  = exp_q.pop_front();
                ei = exp_idx_q.pop_front();
                check("out_data", {out_real, out_imag}, e);
                check("out_index", out_index, ei);
                check("out_last", out_last, ei == N - 1);
                log_real.push_back(out_real);
            end
        end
        in_fired = in_valid && in_ready;
        if (in_fired) begin
            part.push_back({in_real, in_imag});
            if (part.size() == N) begin
                for (int j = 0; j < N; j++) begin
                    exp_q.push_back(part[rev(j, NL)]);
                    exp_idx_q.push_back(j);
                end
                part.delete();
                last_in_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_feed(input int n, input int k0, input int budget);
        int k = 0;
        for (int c = 0; c < budget && k < n; c++) begin
            int kk = k0 + k;
            in_valid = 1'b1;
            case (data_mode)
                0:       begin in_real = 32'(kk);   in_imag = 32'(100 + kk); end
                1:       begin in_real = $urandom;  in_imag = 32'(1000 * (kk / N) + kk % N); end
                default: begin in_real = $urandom;  in_imag = $urandom; end
            endcase
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            cycle();
            if (in_fired) k++;
        end
        in_valid = 1'b0;
        check("feed_count", k, n);
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < budget && (exp_q.size() != 0 || out_valid); c++) cycle();
        check("drain_empty", exp_q.size(), 0);
        cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          accepted;
        int          bk, bn;
        logic [31:0] br[2];
        logic        bl[2];
        logic        bi[2];
        logic [31:0] t1_exp[8];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_real = '0; in_imag = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_real = '0; b_in_imag = '0;
        chk_ready = 1'b0; hold = 1'b0;
        data_mode = 0; rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {out_valid, out_last, out_index, out_real, out_imag}, 0);
        check("reset_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed frame: arrival k -> real k, imag 100+k
        t1_exp = '{0, 4, 2, 6, 1, 5, 3, 7};
        log_real.delete();
        first_out_cyc = -1;
        data_mode = 0; rdy_mode = 0;
        run_feed(N, 0, 40);
        drain(40);
        check("t1_latency", first_out_cyc, last_in_cyc + 2);
        check("t1_count", log_real.size(), N);
        for (int i = 0; i < N && i < log_real.size(); i++) check("t1_order", log_real[i], t1_exp[i]);

        // Three back-to-back frames, both sides ready
        max_run = 0; chk_ready = 1'b1;
        data_mode = 1; rdy_mode = 0;
        run_feed(3 * N, 0, 60);
        chk_ready = 1'b0;
        drain(60);
        check("b2b_valid_run", max_run, 3 * N);

        // Downstream stalled: two banks fill, then upstream stalls
        accepted = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid = 1'b1;
            in_real  = $urandom;
            in_imag  = 32'(1000 * (accepted / N) + accepted % N);
            cycle();
            if (in_fired) accepted++;
        end
        in_valid = 1'b0;
        check("stall_accepted", accepted, 2 * N);
        check("stall_ready", in_ready, 0);
        check("stall_valid", {out_valid, out_index}, {1'b1, 3'd0});
        if (exp_q.size() != 0) check("stall_head", {out_real, out_imag}, exp_q[0]);
        data_mode = 1; rdy_mode = 0;
        run_feed(N, 2 * N, 60);
        drain(80);

        // Random downstream backpressure with continuous input
        data_mode = 2; rdy_mode = 2;
        run_feed(5 * N, 0, 400);
        drain(200);

        // Reset with partial input frame and output mid-frame
        data_mode = 2; rdy_mode = 0;
        run_feed(N, 0, 40);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; in_real = $urandom; in_imag = $urandom; out_ready = 1'b1;
            cycle();
            if (s_valid && s_index == 3) break;
        end
        check("mid_index_seen", {s_valid, 3'(s_index)}, {1'b1, 3'd3});
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {out_valid, out_last, out_index, out_real, out_imag}, 0);
        in_valid = 1'b0;
        part.delete(); exp_q.delete(); exp_idx_q.delete(); hold = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_ready", {in_ready, out_valid}, 2'b10);
        run_feed(N, 0, 40);
        drain(40);

        // N = 2 instance: identity reorder
        bk = 0; bn = 0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            b_in_valid = (bk < 2);
            b_in_real  = 32'(10 + bk);
            b_in_imag  = 32'(bk);
            @(negedge clk);
            if (b_out_valid && b_out_ready) begin
                if (bn < 2) begin
                    br[bn] = b_out_real; bl[bn] = b_out_last; bi[bn] = b_out_index[0];
                end
                bn++;
            end
            if (b_in_valid && b_in_ready) bk++;
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        check("n2_count", bn, 2);
        if (bn >= 2) begin
            check("n2_real", {br[0], br[1]}, {32'd10, 32'd11});
            check("n2_last", {bl[0], bl[1]}, 2'b01);
            check("n2_index", {bi[0], bi[1]}, 2'b01);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
